// File: rtl/ula_sequencer_if.sv
// Fetch-side handshake, ALU control and register-file write-back bundle for ula_sequencer.
// master = sequencer side, slave = fetch/ALU/register-file side.
interface ula_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr;
    logic [5:0]        ulacode;
    logic [3:0]        sel_a;
    logic [3:0]        sel_b;
    logic [DATA_W-1:0] alu_result;
    logic              reg_we;
    logic [3:0]        sel_d;
    logic [DATA_W-1:0] wb_data;
    logic              busy;
    logic              halted;
    logic [CNT_W-1:0]  retired;

    modport master (
        input  instr_valid, instr, alu_result,
        output instr_ready, ulacode, sel_a, sel_b, reg_we, sel_d, wb_data,
               busy, halted, retired
    );

    modport slave (
        output instr_valid, instr, alu_result,
        input  instr_ready, ulacode, sel_a, sel_b, reg_we, sel_d, wb_data,
               busy, halted, retired
    );
endinterface

// File: rtl/ula_sequencer.sv
// Multi-cycle ALU control unit: decode opcode to ulacode, execute one cycle, write back.
// Latency: accept on edge 0, ulacode valid cycle 2, reg_we cycle 3, ready again cycle 4.
// Backpressure: instr_ready low outside IDLE; held instructions wait, HALT refuses all.
module ula_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    ula_sequencer_if.master   bus
);
    localparam logic [5:0] UC_PASS_B = 6'b010100;

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, HALT} state_t;

    state_t            state;
    logic [3:0]        opcode;
    logic              instr_ready;
    logic              reg_we;
    logic              busy;
    logic              halted;
    logic [5:0]        ulacode;
    logic [3:0]        sel_a;
    logic [3:0]        sel_b;
    logic [3:0]        sel_d;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  retired;

    function automatic logic [5:0] ucode_of(input logic [3:0] op);
        logic [5:0] uc;
        case (op)
            4'h0:    uc = 6'b011000;
            4'h1:    uc = 6'b010100;
            4'h2:    uc = 6'b011010;
            4'h3:    uc = 6'b101100;
            4'h4:    uc = 6'b111100;
            4'h5:    uc = 6'b111101;
            4'h6:    uc = 6'b111001;
            4'h7:    uc = 6'b110101;
            4'h8:    uc = 6'b111111;
            4'h9:    uc = 6'b110110;
            4'hA:    uc = 6'b111011;
            4'hB:    uc = 6'b001100;
            4'hC:    uc = 6'b011100;
            4'hD:    uc = 6'b010000;
            4'hE:    uc = 6'b110001;
            default: uc = UC_PASS_B;
        endcase
        return uc;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            opcode      <= 4'h0;
            instr_ready <= 1'b1;
            reg_we      <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            ulacode     <= UC_PASS_B;
            sel_a       <= 4'h0;
            sel_b       <= 4'h0;
            sel_d       <= 4'h0;
            wb_data     <= '0;
            retired     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Selects load straight from the accepted word so they are valid during DECODE.
                    if (bus.instr_valid && instr_ready) begin
                        opcode      <= bus.instr[15:12];
                        sel_d       <= bus.instr[11:8];
                        sel_a       <= bus.instr[7:4];
                        sel_b       <= bus.instr[3:0];
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    if (opcode == 4'hF) begin
                        halted <= 1'b1;
                        busy   <= 1'b0;
                        state  <= HALT;
                    end else begin
                        ulacode <= ucode_of(opcode);
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    wb_data <= bus.alu_result;
                    ulacode <= UC_PASS_B;
                    reg_we  <= 1'b1;
                    state   <= WB;
                end
                WB: begin
                    reg_we      <= 1'b0;
                    retired     <= retired + 1'b1;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.ulacode     = ulacode;
    assign bus.sel_a       = sel_a;
    assign bus.sel_b       = sel_b;
    assign bus.sel_d       = sel_d;
    assign bus.reg_we      = reg_we;
    assign bus.wb_data     = wb_data;
    assign bus.busy        = busy;
    assign bus.halted      = halted;
    assign bus.retired     = retired;
endmodule

// File: tb/tb_ula_sequencer.sv
// Scoreboard bench for ula_sequencer: a register-file/ALU model feeds alu_result,
// the driver queues hand-computed write-backs, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_ula_sequencer;
    localparam logic [5:0] PASS_B = 6'b010100;

    typedef struct packed {
        logic [5:0]  uc;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [3:0]  sd;
        logic [31:0] wb;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_acc = -1;
    bit   stream_mode = 1'b0;
    logic [5:0] prev_uc;
    exp_t q[$];
    exp_t mon_e;

    ula_sequencer_if #(.DATA_W(32), .CNT_W(16)) vif();
    ula_sequencer_if #(.DATA_W(32), .CNT_W(2))  vif2();

    ula_sequencer #(.DATA_W(32), .CNT_W(16)) dut  (.clock(clock), .reset(reset), .bus(vif));
    ula_sequencer #(.DATA_W(32), .CNT_W(2))  dut2 (.clock(clock), .reset(reset), .bus(vif2));

    always #5 clock = ~clock;

    assign vif2.instr_valid = vif.instr_valid;
    assign vif2.instr       = vif.instr;
    assign vif2.alu_result  = 32'd0;

    // Register file model: r[i] = i + 2, so r1 = 3 and r2 = 4.
    logic [31:0] alu_a, alu_b;
    assign alu_a = {28'd0, vif.sel_a} + 32'd2;
    assign alu_b = {28'd0, vif.sel_b} + 32'd2;

    always_comb begin
        vif.alu_result = 32'hDEADBEEF;
        case (vif.ulacode)
            6'b011000: vif.alu_result = alu_a;
            6'b010100: vif.alu_result = alu_b;
            6'b011010: vif.alu_result = ~alu_a;
            6'b101100: vif.alu_result = ~alu_b;
            6'b111100: vif.alu_result = alu_a + alu_b;
            6'b111101: vif.alu_result = alu_a + alu_b + 32'd1;
            6'b111001: vif.alu_result = alu_a + 32'd1;
            6'b110101: vif.alu_result = alu_b + 32'd1;
            6'b111111: vif.alu_result = alu_b - alu_a;
            6'b110110: vif.alu_result = alu_b - 32'd1;
            6'b111011: vif.alu_result = 32'd0 - alu_a;
            6'b001100: vif.alu_result = alu_a & alu_b;
            6'b011100: vif.alu_result = alu_a | alu_b;
            6'b010000: vif.alu_result = 32'd0;
            6'b110001: vif.alu_result = 32'd1;
            default:   vif.alu_result = 32'hDEADBEEF;
        endcase
    end

    logic [5:0]  uc_tab [15] = '{6'b011000, 6'b010100, 6'b011010, 6'b101100, 6'b111100,
                                 6'b111101, 6'b111001, 6'b110101, 6'b111111, 6'b110110,
                                 6'b111011, 6'b001100, 6'b011100, 6'b010000, 6'b110001};
    // Hand-computed results for A = 3, B = 4.
    logic [31:0] wb_tab [15] = '{32'd3, 32'd4, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'd7,
                                 32'd8, 32'd4, 32'd5, 32'd1, 32'd3,
                                 32'hFFFFFFFD, 32'd0, 32'd7, 32'd0, 32'd1};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic present(input logic [15:0] w);
        @(negedge clock);
        vif.instr_valid = 1'b1;
        vif.instr       = w;
    endtask

    task automatic wait_accept(input bit push, input logic [5:0] uc, input logic [31:0] wb);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (vif.instr_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: instr %h never accepted within 40 cycles", vif.instr);
            vif.instr_valid = 1'b0;
        end else begin
            if (push) begin
                e.uc = uc;
                e.sa = vif.instr[7:4];
                e.sb = vif.instr[3:0];
                e.sd = vif.instr[11:8];
                e.wb = wb;
                q.push_back(e);
            end
            @(posedge clock);
            #1 vif.instr_valid = 1'b0;
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (vif.reg_we === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_reg_we: got write sel_d=%0d wb=%h, required no write", vif.sel_d, vif.wb_data);
            end else begin
                mon_e = q.pop_front();
                chk("exec_ulacode", {58'd0, prev_uc}, {58'd0, mon_e.uc});
                chk("wb_ulacode_pass_b", {58'd0, vif.ulacode}, {58'd0, PASS_B});
                chk("wb_sel_a", {60'd0, vif.sel_a}, {60'd0, mon_e.sa});
                chk("wb_sel_b", {60'd0, vif.sel_b}, {60'd0, mon_e.sb});
                chk("wb_sel_d", {60'd0, vif.sel_d}, {60'd0, mon_e.sd});
                chk("wb_data", {32'd0, vif.wb_data}, {32'd0, mon_e.wb});
            end
        end
        if (vif.instr_valid === 1'b1 && vif.instr_ready === 1'b1) begin
            if (stream_mode && last_acc >= 0) chk("accept_interval", 64'(cyc - last_acc), 64'd4);
            last_acc <= stream_mode ? cyc : -1;
        end else if (!stream_mode) begin
            last_acc <= -1;
        end
        prev_uc <= vif.ulacode;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vif.instr_valid = 1'b0;
        vif.instr       = 16'h0000;

        // Reset then idle
        do_reset();
        repeat (3) @(negedge clock);
        chk("rst_ready", {63'd0, vif.instr_ready}, 64'd1);
        chk("rst_ulacode", {58'd0, vif.ulacode}, {58'd0, PASS_B});
        chk("rst_retired", {48'd0, vif.retired}, 64'd0);
        chk("rst_busy_halted", {62'd0, vif.busy, vif.halted}, 64'd0);
        chk("rst_reg_we", {63'd0, vif.reg_we}, 64'd0);
        chk("rst_wb_data", {32'd0, vif.wb_data}, 64'd0);

        // Reset in the middle of EXEC drops the write
        present(16'h4312);
        wait_accept(1'b1, 6'b111100, 32'd7);
        @(negedge clock);
        @(negedge clock);
        chk("midop_exec_ulacode", {58'd0, vif.ulacode}, {58'd0, 6'b111100});
        reset = 1'b1;
        q.delete();
        @(negedge clock);
        chk("midop_reg_we", {63'd0, vif.reg_we}, 64'd0);
        chk("midop_idle", {62'd0, vif.instr_ready, vif.busy}, 64'd2);
        chk("midop_wb_data", {32'd0, vif.wb_data}, 64'd0);
        chk("midop_ulacode", {58'd0, vif.ulacode}, {58'd0, PASS_B});
        reset = 1'b0;

        // Single ADD
        present(16'h4312);
        wait_accept(1'b1, 6'b111100, 32'd7);
        @(negedge clock);
        chk("add_c1_sel_a", {60'd0, vif.sel_a}, 64'd1);
        chk("add_c1_sel_b", {60'd0, vif.sel_b}, 64'd2);
        chk("add_c1_ulacode", {58'd0, vif.ulacode}, {58'd0, PASS_B});
        chk("add_c1_ready_busy", {62'd0, vif.instr_ready, vif.busy}, 64'd1);
        @(negedge clock);
        chk("add_c2_ulacode", {58'd0, vif.ulacode}, {58'd0, 6'b111100});
        @(negedge clock);
        chk("add_c3_reg_we", {63'd0, vif.reg_we}, 64'd1);
        chk("add_c3_sel_d", {60'd0, vif.sel_d}, 64'd3);
        chk("add_c3_wb_data", {32'd0, vif.wb_data}, 64'd7);
        @(negedge clock);
        chk("add_c4_retired", {48'd0, vif.retired}, 64'd1);
        chk("add_c4_ready", {62'd0, vif.instr_ready, vif.reg_we}, 64'd2);

        // Back-to-back stream of opcodes 0..E
        stream_mode = 1'b1;
        for (int k = 0; k < 15; k++) begin
            logic [3:0] k4;
            k4 = 4'(k);
            present({k4, k4, 4'h1, 4'h2});
            wait_accept(1'b1, uc_tab[k], wb_tab[k]);
            if (k == 4) begin
                chk("stream_retired_5", {48'd0, vif.retired}, 64'd5);
                chk("wrap_cnt2_retired", {62'd0, vif2.retired}, 64'd1);
            end
        end
        repeat (4) @(negedge clock);
        stream_mode = 1'b0;
        chk("stream_retired_16", {48'd0, vif.retired}, 64'd16);
        chk("wrap_cnt2_retired_16", {62'd0, vif2.retired}, 64'd0);
        chk("stream_queue_empty", 64'(q.size()), 64'd0);

        // Backpressure: B000 presented while the prior op is in EXEC
        present(16'h4312);
        wait_accept(1'b1, 6'b111100, 32'd7);
        @(negedge clock);
        @(negedge clock);
        vif.instr_valid = 1'b1;
        vif.instr       = 16'hB000;
        chk("bp_exec_ulacode", {58'd0, vif.ulacode}, {58'd0, 6'b111100});
        chk("bp_ready_low", {63'd0, vif.instr_ready}, 64'd0);
        wait_accept(1'b1, 6'b001100, 32'd2);
        repeat (6) @(negedge clock);
        chk("bp_retired", {48'd0, vif.retired}, 64'd18);
        chk("bp_queue_empty", 64'(q.size()), 64'd0);

        // Halt
        present(16'hF000);
        wait_accept(1'b0, PASS_B, 32'd0);
        @(negedge clock);
        chk("halt_c1_halted", {62'd0, vif.halted, vif.busy}, 64'd1);
        @(negedge clock);
        chk("halt_c2_halted", {63'd0, vif.halted}, 64'd1);
        chk("halt_c2_ready_busy", {62'd0, vif.instr_ready, vif.busy}, 64'd0);
        present(16'h4312);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("halt_ignores_valid", {62'd0, vif.instr_ready, vif.halted}, 64'd1);
        end
        chk("halt_retired", {48'd0, vif.retired}, 64'd18);
        vif.instr_valid = 1'b0;
        do_reset();
        chk("halt_reset_halted", {63'd0, vif.halted}, 64'd0);
        chk("halt_reset_ready", {63'd0, vif.instr_ready}, 64'd1);
        chk("halt_reset_retired", {48'd0, vif.retired}, 64'd0);
        repeat (3) @(negedge clock);
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
